// File: rtl/stg_fetch_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction-memory port, IF/ID outputs.
// Master modport is the fetch stage; slave is the surrounding pipeline/memory.
interface stg_fetch_if #(
  parameter int unsigned P_ADDR_W  = 24,
  parameter int unsigned P_INSTR_W = 24
);
  logic                 iw_stall;
  logic                 iw_branch_taken;
  logic [P_ADDR_W-1:0]  iw_branch_pc;
  logic [P_ADDR_W-1:0]  ow_imem_addr;
  logic                 ow_imem_rd;
  logic [P_INSTR_W-1:0] iw_imem_data;
  logic [P_ADDR_W-1:0]  ow_ifid_pc;
  logic [P_INSTR_W-1:0] ow_ifid_instr;
  logic                 ow_ifid_valid;

  modport master (
    input  iw_stall, iw_branch_taken, iw_branch_pc, iw_imem_data,
    output ow_imem_addr, ow_imem_rd, ow_ifid_pc, ow_ifid_instr, ow_ifid_valid
  );

  modport slave (
    output iw_stall, iw_branch_taken, iw_branch_pc, iw_imem_data,
    input  ow_imem_addr, ow_imem_rd, ow_ifid_pc, ow_ifid_instr, ow_ifid_valid
  );
endinterface

// File: rtl/stg_fetch.sv
// Instruction-fetch stage with IF/ID register and one-entry skid buffer.
// Define FETCH_STATS_EN to add saturating stall-cycle and flush counters.
module stg_fetch #(
  parameter int unsigned         P_ADDR_W   = 24,
  parameter int unsigned         P_INSTR_W  = 24,
  parameter logic [P_ADDR_W-1:0] P_RESET_PC = '0
) (
  input  logic          iw_clk,
  input  logic          iw_rst,
  stg_fetch_if.master   bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]   ow_stall_cycles,
  output logic [15:0]   ow_flush_cnt
`endif
);

  logic [P_ADDR_W-1:0]  r_pc;
  logic [P_ADDR_W-1:0]  r_req_pc;
  logic                 r_req_valid;
  logic [P_ADDR_W-1:0]  r_skid_pc;
  logic [P_INSTR_W-1:0] r_skid_instr;
  logic                 r_skid_valid;
  logic [P_ADDR_W-1:0]  r_ifid_pc;
  logic [P_INSTR_W-1:0] r_ifid_instr;
  logic                 r_ifid_valid;
  logic                 w_issue;

  assign w_issue           = !iw_rst && !bus.iw_branch_taken && !bus.iw_stall;
  assign bus.ow_imem_rd    = w_issue;
  assign bus.ow_imem_addr  = r_pc;
  assign bus.ow_ifid_pc    = r_ifid_pc;
  assign bus.ow_ifid_instr = r_ifid_instr;
  assign bus.ow_ifid_valid = r_ifid_valid;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_pc         <= P_RESET_PC;
      r_req_pc     <= '0;
      r_req_valid  <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_skid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else if (bus.iw_branch_taken) begin
      r_pc         <= bus.iw_branch_pc;
      r_req_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ifid_valid <= 1'b0;
    end else if (bus.iw_stall) begin
      // Data for the last issued fetch arrives now; park it so it survives the stall.
      if (r_req_valid) begin
        r_skid_pc    <= r_req_pc;
        r_skid_instr <= bus.iw_imem_data;
        r_skid_valid <= 1'b1;
      end
      r_req_valid <= 1'b0;
    end else begin
      if (r_skid_valid) begin
        r_ifid_pc    <= r_skid_pc;
        r_ifid_instr <= r_skid_instr;
        r_ifid_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_ifid_pc    <= r_req_pc;
        r_ifid_instr <= bus.iw_imem_data;
        r_ifid_valid <= r_req_valid;
      end
      r_req_pc    <= r_pc;
      r_req_valid <= 1'b1;
      r_pc        <= r_pc + P_ADDR_W'(1);
    end
  end

  a_skid_req_exclusive : assert property (@(posedge iw_clk) disable iff (iw_rst)
    !(r_skid_valid && r_req_valid));

`ifdef FETCH_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_stall_cycles <= '0;
      r_flush_cnt    <= '0;
    end else if (bus.iw_branch_taken) begin
      if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (bus.iw_stall) begin
      if (r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign ow_stall_cycles = r_stall_cycles;
  assign ow_flush_cnt    = r_flush_cnt;
`endif

endmodule
